// File: rtl/arb_stream_receiver.sv
// arb_stream_receiver: far-end receiver for the 16-channel arbiter link.
// Frames the K-char delimited word stream, checks the header length, tags each
// payload word with its source channel and buffers it in a valid/ready FIFO.
// Optional build macro ARB_RX_CHECKSUM_EN: each frame carries an XOR trailer
// word that is checked before the last payload word is released.
module arb_stream_receiver #(
    parameter int unsigned MAXLEN  = 512,
    parameter int unsigned FIFO_AW = 4,
    parameter logic [15:0] KIDLE   = 16'h50BC
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_din,
    input  logic        i_kchar,
    output logic [15:0] o_dout,
    output logic [3:0]  o_dchan,
    output logic        o_dvalid,
    input  logic        i_dready,
    output logic        o_dsof,
    output logic        o_deof,
    output logic        o_derr,
    output logic        o_err_len,
    output logic        o_err_k,
    output logic        o_err_ovf,
    output logic [15:0] o_frame_cnt
);
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = 12;
    localparam int unsigned EW    = DW + CW + 3;   // {data, chan, sof, eof, err}
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNTW  = FIFO_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_SKIP, S_TRAIL} state_t;

    state_t               r_state, w_state_nxt;
    logic [DW-1:0]        r_din;
    logic                 r_k;
    logic [CW-1:0]        r_chan;
    logic [LW-1:0]        r_cnt;
    logic                 r_first;
`ifdef ARB_RX_CHECKSUM_EN
    logic [DW-1:0]        r_xor;
    logic [DW-1:0]        r_hold;
    logic                 r_hold_sof;
`endif
    logic [LW-1:0]        w_hdr_len;
    logic                 w_hdr_bad, w_last;
    logic                 w_push, w_psof, w_peof, w_perr, w_err_len, w_err_k;
    logic [DW-1:0]        w_pdata;
    logic                 r_wr, r_err_len, r_err_k, r_err_ovf;
    logic [EW-1:0]        r_wentry;
    logic [EW-1:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr, w_rptr_nxt;
    logic [CNTW-1:0]      r_count, w_head_cnt;
    logic                 w_full, w_pop, w_wr_ok;
    logic [EW-1:0]        r_head;
    logic                 r_dvalid;
    logic [15:0]          r_frame_cnt;

    assign w_hdr_len = r_din[LW-1:0];
    assign w_hdr_bad = (w_hdr_len == '0) || (32'(w_hdr_len) > MAXLEN);
    assign w_last    = (r_cnt == LW'(1));

    // Input stage; the pipe powers up looking like an idle comma
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_din <= KIDLE;
            r_k   <= 1'b1;
        end else begin
            r_din <= i_din;
            r_k   <= i_kchar;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!r_k) w_state_nxt = w_hdr_bad ? S_SKIP : S_PAYLOAD;
            S_PAYLOAD: begin
                if (r_k) w_state_nxt = S_IDLE;
`ifdef ARB_RX_CHECKSUM_EN
                else if (w_last) w_state_nxt = S_TRAIL;
`else
                else if (w_last) w_state_nxt = S_IDLE;
`endif
            end
            S_SKIP:    if (r_k) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO push request and error pulses
    always_comb begin
        w_push    = 1'b0;
        w_pdata   = '0;
        w_psof    = 1'b0;
        w_peof    = 1'b0;
        w_perr    = 1'b0;
        w_err_len = 1'b0;
        w_err_k   = 1'b0;
        case (r_state)
            S_IDLE: w_err_len = !r_k && w_hdr_bad;
            S_PAYLOAD: begin
                if (r_k) begin
                    // truncated frame: close it with an error filler
                    w_err_k = 1'b1;
                    w_push  = 1'b1;
                    w_peof  = 1'b1;
                    w_perr  = 1'b1;
                end else begin
`ifdef ARB_RX_CHECKSUM_EN
                    w_push  = !w_last;
`else
                    w_push  = 1'b1;
                    w_peof  = w_last;
`endif
                    w_pdata = r_din;
                    w_psof  = r_first;
                end
            end
`ifdef ARB_RX_CHECKSUM_EN
            S_TRAIL: begin
                w_push  = 1'b1;
                w_pdata = r_hold;
                w_psof  = r_hold_sof;
                w_peof  = 1'b1;
                w_err_k = r_k;
                w_perr  = r_k || (r_din != r_xor);
            end
`endif
            default: ;
        endcase
    end

    // Frame context: channel, remaining length, first-word flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chan     <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
`ifdef ARB_RX_CHECKSUM_EN
            r_xor      <= '0;
            r_hold     <= '0;
            r_hold_sof <= 1'b0;
`endif
        end else if (r_state == S_IDLE && !r_k) begin
            r_chan  <= r_din[DW-1:LW];
            r_cnt   <= w_hdr_len;
            r_first <= 1'b1;
`ifdef ARB_RX_CHECKSUM_EN
            r_xor   <= r_din;
`endif
        end else if (r_state == S_PAYLOAD && !r_k) begin
            r_cnt   <= r_cnt - LW'(1);
            r_first <= 1'b0;
`ifdef ARB_RX_CHECKSUM_EN
            r_xor   <= r_xor ^ r_din;
            if (w_last) begin
                r_hold     <= r_din;
                r_hold_sof <= r_first;
            end
`endif
        end
    end

    // Registered push request and error pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr      <= 1'b0;
            r_wentry  <= '0;
            r_err_len <= 1'b0;
            r_err_k   <= 1'b0;
        end else begin
            r_wr      <= w_push;
            r_wentry  <= {w_pdata, r_chan, w_psof, w_peof, w_perr};
            r_err_len <= w_err_len;
            r_err_k   <= w_err_k;
        end
    end

    assign w_pop      = r_dvalid && i_dready;
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_wr_ok    = r_wr && (!w_full || w_pop);
    assign w_rptr_nxt = r_rptr + FIFO_AW'(w_pop);
    assign w_head_cnt = r_count - CNTW'(w_pop);

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= r_wentry;
    end

    // FIFO pointers, occupancy, overflow flag, registered head and frame counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_err_ovf   <= 1'b0;
            r_head      <= '0;
            r_dvalid    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + FIFO_AW'(1);
            r_rptr <= w_rptr_nxt;
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (r_wr && !w_wr_ok) r_err_ovf <= 1'b1;
            r_dvalid <= (w_head_cnt != '0);
            r_head   <= (w_head_cnt != '0) ? r_mem[w_rptr_nxt] : '0;
            if (w_pop && r_head[1] && !r_head[0]) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_dout      = r_head[3+CW +: DW];
    assign o_dchan     = r_head[3 +: CW];
    assign o_dsof      = r_head[2];
    assign o_deof      = r_head[1];
    assign o_derr      = r_head[0];
    assign o_dvalid    = r_dvalid;
    assign o_err_len   = r_err_len;
    assign o_err_k     = r_err_k;
    assign o_err_ovf   = r_err_ovf;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: doc/arb_stream_receiver.md
Name: arb_stream_receiver

Overview:
- Far-end receiver for the 16-channel arbiter link: a 16-bit word stream plus a K-character flag per clock.
- Detects frame boundaries, checks length, and demultiplexes each frame into a word stream tagged with the source channel.
- Buffers the stream in a FIFO with a valid/ready interface toward downstream block storage.
- Sits directly behind the link deserializer in the collector FPGA.

Parameters:
MAXLEN, 512, largest legal payload length in words
FIFO_AW, 4, log2 of output FIFO depth (16 entries)
KIDLE, 16'h50BC, idle/comma word sent with kchar=1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
din  in  16  link data word
kchar  in  1  din is a K character (idle)
dout  out  16  payload word
dchan  out  4  source channel of dout
dvalid  out  1  dout/dchan/dsof/deof/derr valid
dready  in  1  downstream accepts word when dvalid&dready
dsof  out  1  first payload word of frame
deof  out  1  last word of frame
derr  out  1  frame is bad; only meaningful with deof
err_len  out  1  one-clock pulse: illegal header length
err_k  out  1  one-clock pulse: K char inside payload
err_ovf  out  1  sticky: FIFO overflow, cleared only by reset
frame_cnt  out  16  count of frames delivered with derr=0, wraps

Behaviour:
- Reset (async): all outputs 0; FIFO empty; state IDLE; frame_cnt=0.
- Input stage: din/kchar registered once before the FSM.
- Frame format: header word (kchar=0), then N payload words (kchar=0). Header fields: [15:12]=channel, [11:0]=N.
- IDLE:
  - kchar=1 stays IDLE; any K value is accepted, KIDLE is not checked.
  - kchar=0 word is a header.
  - N==0 or N>MAXLEN: pulse err_len, go to SKIP.
  - Otherwise latch channel, load counter with N, go to PAYLOAD.
- PAYLOAD:
  - Each kchar=0 word is pushed to the FIFO with dchan.
  - dsof=1 on the first word.
  - When the counter reaches 1: deof=1, derr=0. Go to IDLE; a header on the very next clock is accepted (back-to-back frames).
  - kchar=1 in PAYLOAD: pulse err_k, push one filler entry (dout=0, deof=1, derr=1, dsof=0), go to IDLE.
- SKIP: discard kchar=0 words; first kchar=1 goes to IDLE.
- FIFO:
  - Write is blocked when full.
  - Any push while full drops the entry and sets err_ovf.
  - The FSM does not stall on overflow; stream integrity is not guaranteed after err_ovf until reset.
  - Simultaneous read and write when full: the read frees the slot and the write succeeds.
- Output interface:
  - FIFO head shown on dout; dvalid=1 while FIFO not empty.
  - Outputs are held stable while dvalid&!dready.
- Latency: with FIFO empty and dready=1, a payload word sampled on din at edge t appears with dvalid at edge t+3.
- frame_cnt increments when an entry with deof=1, derr=0 is popped (dvalid&dready).
- Reset mid-frame: everything discarded immediately; no partial-frame marker is emitted.

Optional Feature:
- Macro: ARB_RX_CHECKSUM_EN.
- Defined:
  - Each frame ends with one extra trailer word (kchar=0) equal to the XOR of header and all payload words.
  - The last payload word is held internally and pushed with deof=1 after the trailer arrives, with derr = (trailer != computed XOR).
  - The held word is pushed one clock later than without the feature.
  - K char in place of the trailer: err_k pulse, held word pushed with deof=1, derr=1.
- Undefined: no trailer, no XOR logic; the last payload word carries deof directly.

Test Plan:
- Idle KIDLE; header 16'h2003; payload 16'h1234, 16'h5678, 16'h9ABC; idle; dready=1 -> 3 words, dchan=2, dsof on 1234, deof on 9ABC, derr=0; first word 3 clocks after it on din; frame_cnt=1.
- Header 16'h5000 then header 16'h5201 (N=513) -> two err_len pulses; no FIFO writes; frame_cnt=0.
- Header 16'h7004, 2 payload words, then K -> err_k pulse; FIFO gets 2 words plus filler (dout=0, deof=1, derr=1); frame_cnt unchanged.
- Back-to-back headers 16'h0001,AAAA,16'hF001,BBBB with no idle -> AAAA (dchan=0) then BBBB (dchan=15), each dsof=deof=1; frame_cnt=2.
- dready=0, header 16'h1014 (N=20) -> 16 entries accepted; err_ovf set on the 17th; stays 1 after dready=1 until reset.
- Assert reset mid-payload -> dvalid=0 and frame_cnt=0 immediately; after release, a new valid frame is received normally.
- (ARB_RX_CHECKSUM_EN) header 16'h3002, 0001, 0002, trailer 16'h3001 -> derr=0; repeat with trailer 16'h3000 -> deof word derr=1.
